// File: rtl/alu_issue.sv
// alu_issue: execute-stage issue unit between decode and the integer ALU.
// Latches one RV32I/M instruction, holds the ALU inputs across MUL/DIV stalls and hands the result to writeback.
module alu_issue (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    input  logic [31:0] i_imm,
    output logic [2:0]  o_alu_op_mode,
    output logic [2:0]  o_alu_func_op,
    output logic        o_alu_fp_mode,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic        o_alu_stall,
    input  logic        i_alu_stall,
    input  logic [31:0] i_alu_result,
    output logic        o_wb_valid,
    input  logic        i_wb_ready,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_wb_illegal
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;

    localparam logic [2:0] MODE_IDLE    = 3'd0;
    localparam logic [2:0] MODE_LOGIC   = 3'd1;
    localparam logic [2:0] MODE_SHIFT   = 3'd2;
    localparam logic [2:0] MODE_COMPARE = 3'd3;
    localparam logic [2:0] MODE_ADD_SUB = 3'd4;
    localparam logic [2:0] MODE_MUL     = 3'd5;
    localparam logic [2:0] MODE_DIV     = 3'd6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [4:0]  rd_r;
    logic [2:0]  mode_r;
    logic [2:0]  func_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        illegal_r;

    logic [2:0]  dec_mode_s;
    logic [2:0]  dec_func_s;
    logic [31:0] dec_a_s;
    logic [31:0] dec_b_s;
    logic        dec_illegal_s;

    logic        ready_s;
    logic        accept_s;
    logic        in_issue_s;
    logic        in_wb_s;

    assign in_issue_s = (state_r == ST_ISSUE);
    assign in_wb_s    = (state_r == ST_WB);
    assign ready_s    = (state_r == ST_IDLE) | (in_wb_s & i_wb_ready);
    assign accept_s   = i_valid & ready_s;

    // Instruction decode into ALU mode / functional option / operands.
    always_comb begin
        dec_mode_s    = MODE_IDLE;
        dec_func_s    = 3'd0;
        dec_a_s       = 32'd0;
        dec_b_s       = 32'd0;
        dec_illegal_s = 1'b0;
        case (i_opcode)
            OPC_OP, OPC_OP_IMM: begin
                dec_a_s = i_rs1_data;
                if (i_opcode == OPC_OP) begin
                    dec_b_s = i_rs2_data;
                end else begin
                    dec_b_s = i_imm;
                end
                if ((i_opcode == OPC_OP) && (i_funct7 == F7_MULDIV)) begin
                    case (i_funct3)
                        3'b000:  dec_mode_s = MODE_MUL;
                        3'b100:  dec_mode_s = MODE_DIV;
                        3'b110: begin
                            dec_mode_s = MODE_DIV;
                            dec_func_s = 3'b001;
                        end
                        default: dec_illegal_s = 1'b1;
                    endcase
                end else begin
                    case (i_funct3)
                        3'b000: begin
                            // OP-IMM has no subtract form, whatever imm[10] holds.
                            dec_mode_s = MODE_ADD_SUB;
                            if ((i_opcode == OPC_OP) && i_funct7[5]) begin
                                dec_func_s = 3'b001;
                            end else begin
                                dec_func_s = 3'b000;
                            end
                        end
                        3'b001:  dec_mode_s = MODE_SHIFT;
                        3'b101: begin
                            dec_mode_s = MODE_SHIFT;
                            dec_func_s = {1'b0, 1'b1, i_funct7[5]};
                            if (i_opcode == OPC_OP_IMM) begin
                                dec_b_s = i_imm & 32'h0000_001F;
                            end else begin
                                dec_b_s = i_rs2_data;
                            end
                        end
                        3'b010:  dec_mode_s = MODE_COMPARE;
                        3'b100: begin
                            dec_mode_s = MODE_LOGIC;
                            dec_func_s = 3'b010;
                        end
                        3'b110: begin
                            dec_mode_s = MODE_LOGIC;
                            dec_func_s = 3'b001;
                        end
                        3'b111:  dec_mode_s = MODE_LOGIC;
                        default: dec_illegal_s = 1'b1;
                    endcase
                end
            end
            OPC_LUI: begin
                dec_a_s = i_imm;
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Next-state logic; an accept in WB chains straight into the next instruction.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_WB: begin
                if (accept_s) begin
                    if (dec_illegal_s) begin
                        state_nxt_s = ST_WB;
                    end else begin
                        state_nxt_s = ST_ISSUE;
                    end
                end else if (in_wb_s && !i_wb_ready) begin
                    state_nxt_s = ST_WB;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (i_alu_stall) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_WB;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and instruction latch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= ST_IDLE;
            rd_r      <= 5'd0;
            mode_r    <= MODE_IDLE;
            func_r    <= 3'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                rd_r      <= i_rd;
                mode_r    <= dec_mode_s;
                func_r    <= dec_func_s;
                a_r       <= dec_a_s;
                b_r       <= dec_b_s;
                illegal_r <= dec_illegal_s;
            end
        end
    end

    // ALU inputs stay bit-stable through ISSUE; outside it the ALU idles with its result frozen.
    assign o_ready       = ready_s;
    assign o_alu_op_mode = in_issue_s ? mode_r : MODE_IDLE;
    assign o_alu_func_op = in_issue_s ? func_r : 3'd0;
    assign o_alu_fp_mode = 1'b0;
    assign o_alu_a       = in_issue_s ? a_r : 32'd0;
    assign o_alu_b       = in_issue_s ? b_r : 32'd0;
    assign o_alu_stall   = ~in_issue_s;
    assign o_wb_valid    = in_wb_s;
    assign o_wb_rd       = rd_r;
    assign o_wb_data     = (in_wb_s && !illegal_r) ? i_alu_result : 32'd0;
    assign o_wb_illegal  = in_wb_s & illegal_r;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized scoreboard bench for alu_issue with a behavioural ALU model.
// Expected results come from RV32I/M instruction semantics computed directly from the issued fields.
module tb_alu_issue;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [6:0]  i_opcode;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [4:0]  i_rd;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [31:0] i_imm;
    logic [2:0]  o_alu_op_mode;
    logic [2:0]  o_alu_func_op;
    logic        o_alu_fp_mode;
    logic [31:0] o_alu_a;
    logic [31:0] o_alu_b;
    logic        o_alu_stall;
    logic        i_alu_stall;
    logic [31:0] i_alu_result;
    logic        o_wb_valid;
    logic        i_wb_ready;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_wb_illegal;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        illegal;
        int          exp_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   next_n   = 0;
    int   cur_n    = 0;
    int   stall_cnt = 0;
    logic wb_rand_en = 1'b0;
    logic wb_ready_dir = 1'b1;

    alu_issue dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_funct3(i_funct3), .i_funct7(i_funct7), .i_rd(i_rd),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
        .o_alu_op_mode(o_alu_op_mode), .o_alu_func_op(o_alu_func_op), .o_alu_fp_mode(o_alu_fp_mode),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_stall(o_alu_stall),
        .i_alu_stall(i_alu_stall), .i_alu_result(i_alu_result),
        .o_wb_valid(o_wb_valid), .i_wb_ready(i_wb_ready), .o_wb_rd(o_wb_rd),
        .o_wb_data(o_wb_data), .o_wb_illegal(o_wb_illegal)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Behavioural ALU: registered result, MUL/DIV busy for the stall count attached to the instruction.
    function automatic logic [31:0] alu_fn(input logic [2:0] m, input logic [2:0] f,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (m)
            3'd0: r = a;
            3'd1: begin
                if (f == 3'd0) r = a & b;
                else if (f == 3'd1) r = a | b;
                else if (f == 3'd2) r = a ^ b;
                else r = 32'd0;
            end
            3'd2: begin
                if (f == 3'd0) r = a << b[4:0];
                else if (f == 3'd2) r = a >> b[4:0];
                else if (f == 3'd3) r = $signed(a) >>> b[4:0];
                else r = 32'd0;
            end
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: r = f[0] ? (a - b) : (a + b);
            3'd5: r = a * b;
            3'd6: begin
                if (b == 32'd0) r = 32'd0;
                else if (f[0]) r = $signed(a) % $signed(b);
                else r = $signed(a) / $signed(b);
            end
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt    <= 0;
            cur_n        <= 0;
            i_alu_result <= 32'd0;
        end else begin
            if (i_valid && o_ready) cur_n <= next_n;
            if (i_alu_stall) stall_cnt <= stall_cnt + 1;
            else stall_cnt <= 0;
            if (!o_alu_stall) i_alu_result <= alu_fn(o_alu_op_mode, o_alu_func_op, o_alu_a, o_alu_b);
        end
    end

    assign i_alu_stall = !o_alu_stall && ((o_alu_op_mode == 3'd5) || (o_alu_op_mode == 3'd6))
                         && (stall_cnt < cur_n);

    // Reference: architectural result of an RV32I/M instruction.
    function automatic void ref_exec(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                                     output logic ill, output logic [31:0] res);
        logic [31:0] y;
        ill = 1'b0;
        res = 32'd0;
        if (opc == LUI) begin
            res = imm;
        end else if (opc == OP && f7 == 7'd1) begin
            case (f3)
                3'd0: res = rs1 * rs2;
                3'd4: res = $signed(rs1) / $signed(rs2);
                3'd6: res = $signed(rs1) % $signed(rs2);
                default: ill = 1'b1;
            endcase
        end else if (opc == OP || opc == OP_IMM) begin
            y = (opc == OP) ? rs2 : imm;
            case (f3)
                3'd0: res = (opc == OP && f7[5]) ? rs1 - y : rs1 + y;
                3'd1: res = rs1 << y[4:0];
                3'd5: begin
                    if (f7[5]) res = $signed(rs1) >>> y[4:0];
                    else res = rs1 >> y[4:0];
                end
                3'd2: res = ($signed(rs1) < $signed(y)) ? 32'd1 : 32'd0;
                3'd4: res = rs1 ^ y;
                3'd6: res = rs1 | y;
                3'd7: res = rs1 & y;
                default: ill = 1'b1;
            endcase
        end else begin
            ill = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Present one instruction, hold it until accepted, and post its expected writeback.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm, input int n);
        exp_t e;
        int   k;
        int   md;
        i_valid = 1'b1; i_opcode = opc; i_funct3 = f3; i_funct7 = f7; i_rd = rd;
        i_rs1_data = rs1; i_rs2_data = rs2; i_imm = imm; next_n = n;
        k = 0;
        @(negedge i_clk);
        while (!o_ready && k < 60) begin
            @(negedge i_clk);
            k++;
        end
        chk("accept_timeout", 32'(o_ready), 32'd1);
        if (o_ready) begin
            ref_exec(opc, f3, f7, rs1, rs2, imm, e.illegal, e.data);
            e.rd = rd;
            md = (opc == OP && f7 == 7'd1 && !e.illegal) ? n : 0;
            e.exp_cyc = e.illegal ? cyc + 1 : cyc + 2 + md;
            sb_q.push_back(e);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        wb_rand_en = 1'b0;
        wb_ready_dir = 1'b1;
        while (sb_q.size() != 0 && k < 300) begin
            @(posedge i_clk);
            k++;
        end
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic rdy_loop();
        forever begin
            @(posedge i_clk);
            #2;
            i_wb_ready = wb_rand_en ? ($urandom_range(0, 3) != 0) : wb_ready_dir;
        end
    endtask

    // Monitor: pops the scoreboard on each writeback handshake and checks hold/latency rules.
    task automatic mon_loop();
        exp_t        e;
        bit          lat_done = 1'b0;
        bit          hold = 1'b0;
        bit          prev_iss = 1'b0;
        logic [4:0]  h_rd = 5'd0;
        logic [31:0] h_data = 32'd0;
        logic        h_ill = 1'b0;
        logic [2:0]  p_mode = 3'd0;
        logic [2:0]  p_func = 3'd0;
        logic [31:0] p_a = 32'd0;
        logic [31:0] p_b = 32'd0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                lat_done = 1'b0; hold = 1'b0; prev_iss = 1'b0;
            end else begin
                if (!o_alu_stall) begin
                    chk("ready_in_issue", 32'(o_ready), 32'd0);
                    chk("fp_mode", 32'(o_alu_fp_mode), 32'd0);
                    if (prev_iss) begin
                        chk("issue_hold_mode", 32'(o_alu_op_mode), 32'(p_mode));
                        chk("issue_hold_func", 32'(o_alu_func_op), 32'(p_func));
                        chk("issue_hold_a", o_alu_a, p_a);
                        chk("issue_hold_b", o_alu_b, p_b);
                    end
                    prev_iss = 1'b1;
                    p_mode = o_alu_op_mode; p_func = o_alu_func_op; p_a = o_alu_a; p_b = o_alu_b;
                end else begin
                    prev_iss = 1'b0;
                end
                if (o_wb_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("wb_unexpected_valid", 32'(o_wb_valid), 32'd0);
                    end else begin
                        if (!lat_done) begin
                            chk("wb_latency", 32'(cyc), 32'(sb_q[0].exp_cyc));
                            lat_done = 1'b1;
                        end
                        if (hold) begin
                            chk("bp_hold_rd", 32'(o_wb_rd), 32'(h_rd));
                            chk("bp_hold_data", o_wb_data, h_data);
                            chk("bp_hold_illegal", 32'(o_wb_illegal), 32'(h_ill));
                        end
                        if (i_wb_ready) begin
                            e = sb_q.pop_front();
                            chk("wb_rd", 32'(o_wb_rd), 32'(e.rd));
                            chk("wb_data", o_wb_data, e.data);
                            chk("wb_illegal", 32'(o_wb_illegal), 32'(e.illegal));
                            lat_done = 1'b0;
                            hold = 1'b0;
                        end else begin
                            chk("ready_in_bp", 32'(o_ready), 32'd0);
                            hold = 1'b1;
                            h_rd = o_wb_rd; h_data = o_wb_data; h_ill = o_wb_illegal;
                        end
                    end
                end else if (hold) begin
                    chk("wb_dropped", 32'(o_wb_valid), 32'd1);
                    hold = 1'b0;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] r1, r2, r3;
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        int          sel, n;

        i_rst = 1'b1; i_valid = 1'b0; i_opcode = 7'd0; i_funct3 = 3'd0; i_funct7 = 7'd0;
        i_rd = 5'd0; i_rs1_data = 32'd0; i_rs2_data = 32'd0; i_imm = 32'd0; i_wb_ready = 1'b1;
        fork
            mon_loop();
            rdy_loop();
        join_none
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("rst_wb_illegal", 32'(o_wb_illegal), 32'd0);
        chk("rst_mode", 32'(o_alu_op_mode), 32'd0);
        chk("rst_alu_stall", 32'(o_alu_stall), 32'd1);
        chk("rst_alu_a", o_alu_a, 32'd0);
        @(posedge i_clk);
        #1;

        issue(OP, 3'd0, 7'd0, 5'd3, 32'd5, 32'd7, 32'd0, 0);
        @(negedge i_clk);
        chk("add_mode", 32'(o_alu_op_mode), 32'd4);
        chk("add_func", 32'(o_alu_func_op), 32'd0);
        chk("add_a", o_alu_a, 32'd5);
        chk("add_b", o_alu_b, 32'd7);
        @(posedge i_clk); #1;

        issue(OP, 3'd0, 7'b0100000, 5'd4, 32'd3, 32'd10, 32'd0, 0);
        @(negedge i_clk);
        chk("sub_func", 32'(o_alu_func_op), 32'd1);
        @(posedge i_clk); #1;

        issue(OP_IMM, 3'd0, 7'b0100000, 5'd5, 32'd100, 32'd9, 32'h0000_0400, 0);
        @(negedge i_clk);
        chk("addi_func", 32'(o_alu_func_op), 32'd0);
        @(posedge i_clk); #1;

        issue(OP_IMM, 3'd5, 7'b0100000, 5'd6, 32'h8000_0000, 32'd0, 32'h0000_0404, 0);
        @(negedge i_clk);
        chk("srai_mode", 32'(o_alu_op_mode), 32'd2);
        chk("srai_func", 32'(o_alu_func_op), 32'd3);
        chk("srai_b", o_alu_b, 32'd4);
        @(posedge i_clk); #1;

        issue(OP, 3'd0, 7'd1, 5'd7, 32'd6, 32'd7, 32'd0, 5);
        @(negedge i_clk);
        chk("mul_mode", 32'(o_alu_op_mode), 32'd5);
        chk("mul_a", o_alu_a, 32'd6);
        chk("mul_b", o_alu_b, 32'd7);
        @(posedge i_clk); #1;
        issue(OP, 3'd0, 7'd0, 5'd8, 32'd1, 32'd2, 32'd0, 0);
        drain();

        wb_ready_dir = 1'b0;
        issue(OP, 3'd3, 7'd0, 5'd9, 32'd1, 32'd2, 32'd0, 0);
        @(negedge i_clk);
        chk("sltu_wb_valid", 32'(o_wb_valid), 32'd1);
        chk("sltu_illegal", 32'(o_wb_illegal), 32'd1);
        chk("sltu_data", o_wb_data, 32'd0);
        chk("sltu_ready_low", 32'(o_ready), 32'd0);
        repeat (3) @(posedge i_clk);
        #1;
        wb_ready_dir = 1'b1;
        issue(OP, 3'd0, 7'd0, 5'd10, 32'd20, 32'd22, 32'd0, 0);
        @(negedge i_clk);
        chk("b2b_issue", 32'(o_alu_stall), 32'd0);
        chk("b2b_mode", 32'(o_alu_op_mode), 32'd4);
        drain();

        issue(OP, 3'd4, 7'd1, 5'd11, 32'd100, 32'd7, 32'd0, 10);
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        sb_q.delete();
        @(negedge i_clk);
        chk("div_mode_before_rst", 32'(o_alu_op_mode), 32'd6);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("midrst_wb_valid", 32'(o_wb_valid), 32'd0);
        chk("midrst_mode", 32'(o_alu_op_mode), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_alu_stall", 32'(o_alu_stall), 32'd1);
        @(posedge i_clk); #1;

        wb_rand_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            r1 = $urandom; r2 = $urandom; r3 = $urandom;
            f3 = 3'($urandom_range(0, 7));
            f7 = 7'd0;
            n = 0;
            if (sel < 4) begin
                opc = OP;
                case ($urandom_range(0, 2))
                    0: f7 = 7'd0;
                    1: f7 = 7'b0100000;
                    default: f7 = 7'd1;
                endcase
                if (f7 == 7'd1) begin
                    n = $urandom_range(0, 6);
                    if (r2 == 32'd0) r2 = 32'd3;
                    if (r1 == 32'h8000_0000 && r2 == 32'hFFFF_FFFF) r2 = 32'd5;
                end
            end else if (sel < 8) begin
                opc = OP_IMM;
                f7 = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'b0100000;
                r3 = {{20{r3[11]}}, r3[11:0]};
            end else if (sel == 8) begin
                opc = LUI;
                r3 = {r3[31:12], 12'd0};
            end else begin
                opc = 7'b0000011;
            end
            issue(opc, f3, f7, 5'($urandom_range(0, 31)), r1, r2, r3, n);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge i_clk);
                #1;
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
